implication_monitor: RTL and testbench
======================================

Name: implication_monitor

Overview:
Synthesizable runtime checker for the property "antecedent |-> ##DELAY consequent". It sits directly downstream of the registered stage (FF / Main) and consumes its input and registered output, e.g. antecedent = I and consequent = O. It turns the simulation-only assertion into hardware: fail pulses, pass/fail counters, a sticky trip flag and a first-failure timestamp. This makes the check usable on silicon and FPGA, where inline SVA is dropped.

Parameters:
DELAY, 1, cycles between antecedent sample and consequent sample; legal range 1..16.
CNT_W, 8, width of the pass/fail counters and of the cycle timestamp.
STICKY, 1, 1 = first failure latches TRIPPED until clear; 0 = monitor keeps running after failures.

Ports:
CLK  input  1  clock, all state on rising edge.
ASYNCRESETN  input  1  asynchronous active-low reset.
enable  input  1  when high, antecedents are accepted; when low, no new obligations start.
clear  input  1  synchronous clear of all monitor state (pend, counters, state, timestamp).
antecedent  input  1  antecedent signal (e.g. I).
consequent  input  1  consequent signal (e.g. registered O).
fail  output  1  one-cycle registered pulse per violated obligation.
pass  output  1  one-cycle registered pulse per satisfied obligation.
tripped  output  1  high in state TRIPPED.
busy  output  1  at least one obligation in flight (|pend).
fail_count  output  CNT_W  saturating count of failures.
pass_count  output  CNT_W  saturating count of passes.
first_fail_cycle  output  CNT_W  free-running cycle-counter value captured at the first failure since reset/clear.

Behaviour:
- Reset (ASYNCRESETN low, asynchronous): all outputs 0, pend = 0, cycle counter = 0, state = IDLE.
- pend[DELAY-1:0] shift register. At each edge: pend[0] <= antecedent & enable & (state != TRIPPED), and pend[i] <= pend[i-1].
- Evaluation at each edge, using the values sampled just before the edge:
  - fail <= pend[DELAY-1] & ~consequent
  - pass <= pend[DELAY-1] & consequent
- Latency: antecedent sampled at edge k, consequent sampled at edge k+DELAY, and fail/pass are high during the cycle after edge k+DELAY.
- Overlapping obligations (antecedent high on consecutive cycles) are each checked independently. No merging.
- Counters increment on the same edge that sets fail/pass. They saturate at 2^CNT_W-1 and never wrap.
- The cycle counter increments every edge while state != IDLE and wraps modulo 2^CNT_W. On the edge that first sets fail since reset/clear, first_fail_cycle <= current cycle counter value. Later failures do not update it.
- FSM states: IDLE, MONITOR, TRIPPED.
  - IDLE -> MONITOR when enable is high.
  - MONITOR -> IDLE when enable is low and busy == 0.
  - With enable low and busy == 1, the FSM stays in MONITOR until the in-flight obligations drain. They are still checked.
  - MONITOR -> TRIPPED on a failure when STICKY == 1. With STICKY == 0, the FSM stays in MONITOR.
  - TRIPPED holds until clear. In TRIPPED, new obligations are blocked, in-flight obligations are still evaluated, and counters still update.
- clear has priority over everything except reset:
  - next state = IDLE; pend, counters, timestamp, fail, pass = 0.
  - An antecedent in the clear cycle is discarded.
- Reset mid-obligation: the obligation is dropped, and no fail/pass is reported.
- enable falling in the same cycle as antecedent: that antecedent is not captured.

Decomposition:
- Package implication_monitor_pkg holds:
  - state_t enum {IDLE, MONITOR, TRIPPED};
  - localparam MAX_DELAY = 16;
  - a function sat_inc(count, width) implementing the saturating increment.
- One sub-module, sat_counter (CNT_W, inc, clear, count), instantiated twice: once for pass and once for fail.
- The cycle counter is inline.

Test Plan:
- DELAY=1: antecedent=1 at edge 3, consequent=1 at edge 4 -> pass high during cycle 5, pass_count=1, fail_count=0, tripped=0.
- DELAY=1, STICKY=1: antecedent at edge 3, consequent=0 at edge 4 -> fail pulse in the following cycle, fail_count=1, tripped=1, first_fail_cycle=cycle-counter value at edge 4. A later antecedent does not set busy.
- DELAY=3: antecedent high on edges 2,3,4, consequent high only at edges 5 and 7 -> pass, fail, pass in three consecutive cycles. Counts end at pass=2, fail=1.
- Drain: with DELAY=2, antecedent at edge 5, enable drops at edge 6 -> obligation still evaluated at edge 7 and busy=1 until then. The FSM returns to IDLE afterwards.
- Saturation: CNT_W=4, 20 passing obligations -> pass_count holds at 15.
- clear/reset mid-flight: with DELAY=3, clear pulsed 1 cycle after antecedent -> no pass/fail ever, all counts 0. Repeating with ASYNCRESETN pulsed low between edges gives the same result, and all outputs go to 0 immediately.

Source files
------------

// File: rtl/implication_monitor_pkg.sv
// Shared types and helpers for the antecedent |-> ##DELAY consequent monitor.
// Contents: state_t (FSM encoding), MAX_DELAY, MAX_CNT_W, sat_inc().
package implication_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  // Largest supported antecedent-to-consequent distance in cycles.
  localparam int unsigned MAX_DELAY = 16;
  // Widest counter sat_inc can handle.
  localparam int unsigned MAX_CNT_W = 32;

  // Increment count, holding at the all-ones value of a width-bit counter.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] count,
                                                   input int unsigned          width);
    logic [MAX_CNT_W-1:0] top;
    top = (width >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
    return (count >= top) ? count : count + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async active-low), inc (count one event), clear (sync zero),
//        count (current value, never wraps).
module sat_counter
  import implication_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  // Clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= CNT_W'(sat_inc(MAX_CNT_W'(count), CNT_W));
    end
  end

endmodule

// File: rtl/implication_monitor.sv
// Hardware checker for "antecedent |-> ##DELAY consequent".
// Ports: CLK, ASYNCRESETN (async active-low); enable (accept new antecedents),
//        clear (sync wipe of all state), antecedent, consequent;
//        fail/pass (one-cycle pulse per checked obligation), tripped (sticky stop),
//        busy (obligations in flight), fail_count/pass_count (saturating),
//        first_fail_cycle (cycle-counter value at the first failure).
// DELAY is legal in 1..MAX_DELAY.
module implication_monitor
  import implication_monitor_pkg::*;
#(
  parameter int unsigned DELAY  = 1,
  parameter int unsigned CNT_W  = 8,
  parameter bit          STICKY = 1'b1
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             enable,
  input  logic             clear,
  input  logic             antecedent,
  input  logic             consequent,
  output logic             fail,
  output logic             pass,
  output logic             tripped,
  output logic             busy,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] first_fail_cycle
);

  state_t           state;
  state_t           state_next;
  logic [DELAY-1:0] pend;
  logic [DELAY-1:0] pend_next;
  logic [CNT_W-1:0] cycle_cnt;
  logic             fail_seen;
  logic             due;
  logic             fail_now;
  logic             pass_now;

  // Oldest obligation is judged against the consequent sampled at this edge.
  assign due      = pend[DELAY-1];
  assign fail_now = due & ~consequent;
  assign pass_now = due & consequent;

  // State register.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and obligation shift; clear discards everything including a same-cycle antecedent.
  always_comb begin
    state_next = state;
    pend_next  = '0;
    if (!clear) begin
      pend_next[0] = antecedent & enable & (state != TRIPPED);
      for (int i = 1; i < DELAY; i++) begin
        pend_next[i] = pend[i-1];
      end
    end
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state_next = MONITOR;
        end
        MONITOR: begin
          if (fail_now && STICKY) begin
            state_next = TRIPPED;
          end else if (!enable && (pend == '0)) begin
            state_next = IDLE;
          end
        end
        TRIPPED: state_next = TRIPPED;
        default: state_next = IDLE;
      endcase
    end
  end

  // Obligation pipeline, result pulses, status flags and first-failure timestamp.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      pend             <= '0;
      fail             <= 1'b0;
      pass             <= 1'b0;
      tripped          <= 1'b0;
      busy             <= 1'b0;
      cycle_cnt        <= '0;
      fail_seen        <= 1'b0;
      first_fail_cycle <= '0;
    end else if (clear) begin
      pend             <= '0;
      fail             <= 1'b0;
      pass             <= 1'b0;
      tripped          <= 1'b0;
      busy             <= 1'b0;
      cycle_cnt        <= '0;
      fail_seen        <= 1'b0;
      first_fail_cycle <= '0;
    end else begin
      pend    <= pend_next;
      fail    <= fail_now;
      pass    <= pass_now;
      tripped <= (state_next == TRIPPED);
      busy    <= |pend_next;
      // Timestamp base only advances while the monitor is active; wraps freely.
      if (state != IDLE) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (fail_now && !fail_seen) begin
        fail_seen        <= 1'b1;
        first_fail_cycle <= cycle_cnt;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (CLK),
    .rst_n (ASYNCRESETN),
    .inc   (fail_now),
    .clear (clear),
    .count (fail_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (CLK),
    .rst_n (ASYNCRESETN),
    .inc   (pass_now),
    .clear (clear),
    .count (pass_count)
  );

endmodule

// File: tb/tb_implication_monitor.sv
// Directed, table-driven bench for implication_monitor.
// Three instances share stimulus: a (DELAY=1, CNT_W=4, sticky), b (DELAY=3, CNT_W=8,
// non-sticky), c (DELAY=2, CNT_W=8, non-sticky). Each row names the instance it checks.
module tb_implication_monitor;

  logic CLK = 1'b0;
  logic ASYNCRESETN;
  logic enable, clear, antecedent, consequent;

  logic       a_fail, a_pass, a_trip, a_busy;
  logic [3:0] a_fc, a_pc, a_ffc;
  logic       b_fail, b_pass, b_trip, b_busy;
  logic [7:0] b_fc, b_pc, b_ffc;
  logic       c_fail, c_pass, c_trip, c_busy;
  logic [7:0] c_fc, c_pc, c_ffc;

  always #5 CLK = ~CLK;

  implication_monitor #(.DELAY(1), .CNT_W(4), .STICKY(1'b1)) dut_a (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .enable(enable), .clear(clear),
    .antecedent(antecedent), .consequent(consequent),
    .fail(a_fail), .pass(a_pass), .tripped(a_trip), .busy(a_busy),
    .fail_count(a_fc), .pass_count(a_pc), .first_fail_cycle(a_ffc));

  implication_monitor #(.DELAY(3), .CNT_W(8), .STICKY(1'b0)) dut_b (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .enable(enable), .clear(clear),
    .antecedent(antecedent), .consequent(consequent),
    .fail(b_fail), .pass(b_pass), .tripped(b_trip), .busy(b_busy),
    .fail_count(b_fc), .pass_count(b_pc), .first_fail_cycle(b_ffc));

  implication_monitor #(.DELAY(2), .CNT_W(8), .STICKY(1'b0)) dut_c (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .enable(enable), .clear(clear),
    .antecedent(antecedent), .consequent(consequent),
    .fail(c_fail), .pass(c_pass), .tripped(c_trip), .busy(c_busy),
    .fail_count(c_fc), .pass_count(c_pc), .first_fail_cycle(c_ffc));

  typedef struct {
    bit en, clr, ant, cons;
    int d;
    bit p, f, b, t;
    int pc, fc, ffc;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input bit en, clr, ant, cons, input int d,
                              input bit p, f, b, t, input int pc, fc, ffc);
    vec_t v;
    v.en = en; v.clr = clr; v.ant = ant; v.cons = cons; v.d = d;
    v.p = p; v.f = f; v.b = b; v.t = t; v.pc = pc; v.fc = fc; v.ffc = ffc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int d, output int p, f, b, t, pc, fc, ffc);
    case (d)
      0: begin p = int'(a_pass); f = int'(a_fail); b = int'(a_busy); t = int'(a_trip);
               pc = int'(a_pc); fc = int'(a_fc); ffc = int'(a_ffc); end
      1: begin p = int'(b_pass); f = int'(b_fail); b = int'(b_busy); t = int'(b_trip);
               pc = int'(b_pc); fc = int'(b_fc); ffc = int'(b_ffc); end
      default: begin p = int'(c_pass); f = int'(c_fail); b = int'(c_busy); t = int'(c_trip);
               pc = int'(c_pc); fc = int'(c_fc); ffc = int'(c_ffc); end
    endcase
  endtask

  task automatic check_dut(input string tag, input int d, input int ep, ef, eb, et,
                           input int epc, efc, effc);
    int p, f, b, t, pc, fc, ffc;
    sample(d, p, f, b, t, pc, fc, ffc);
    chk({tag, ".pass"}, p, ep);
    chk({tag, ".fail"}, f, ef);
    chk({tag, ".busy"}, b, eb);
    chk({tag, ".tripped"}, t, et);
    chk({tag, ".pass_count"}, pc, epc);
    chk({tag, ".fail_count"}, fc, efc);
    chk({tag, ".first_fail_cycle"}, ffc, effc);
  endtask

  // Drive one cycle of inputs, let the edge happen, settle 1 time unit past it.
  task automatic cyc(input bit en, clr, ant, cons);
    enable = en; clear = clr; antecedent = ant; consequent = cons;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    enable = 1'b0; clear = 1'b0; antecedent = 1'b0; consequent = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < 3; d++) check_dut($sformatf("reset%0d", d), d, 0, 0, 0, 0, 0, 0, 0);
    ASYNCRESETN = 1'b1;

    //               en clr ant cons dut  p f b t  pc fc ffc
    // DELAY=1 pass
    vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 1, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0,  1, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0));
    // DELAY=1 sticky failure, then blocked antecedent, then clear releases
    vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0, 0, 1, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 1,  0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 1, 0,  0, 0, 0, 1,  0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0,  0, 0, 0, 1,  0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    // DELAY=3 overlapping obligations: pass, fail, pass
    vecs.push_back(mk(1, 1, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1,  0, 0, 1, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1,  0, 0, 1, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1,  0, 0, 1, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1,  1, 0, 1, 0,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 1, 1, 0,  1, 1, 4));
    vecs.push_back(mk(1, 0, 0, 1, 1,  1, 0, 0, 0,  2, 1, 4));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, 0,  2, 1, 4));
    // DELAY=2 drain after enable drops, return to IDLE (cycle counter pauses)
    vecs.push_back(mk(1, 1, 0, 0, 2,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 2,  0, 0, 1, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2,  0, 0, 1, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2,  1, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2,  0, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2,  0, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2,  0, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 2,  0, 0, 1, 0,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2,  0, 0, 1, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2,  0, 1, 0, 0,  1, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 2,  0, 0, 0, 0,  1, 1, 5));
    // DELAY=3 clear one cycle after antecedent (same-cycle antecedent discarded)
    vecs.push_back(mk(1, 1, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1,  0, 0, 1, 0,  0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].clr, vecs[i].ant, vecs[i].cons);
      check_dut($sformatf("row%0d", i), vecs[i].d, vecs[i].p, vecs[i].f, vecs[i].b,
                vecs[i].t, vecs[i].pc, vecs[i].fc, vecs[i].ffc);
    end

    // Saturation: continuous passing obligations; 4-bit counter must hold at 15.
    cyc(1, 1, 0, 0);
    for (int k = 1; k <= 21; k++) begin
      cyc(1, 0, 1, 1);
      if (k == 17) chk("sat_a_pc_edge17", int'(a_pc), 15);
    end
    chk("sat_a_pc", int'(a_pc), 15);
    chk("sat_a_pass", int'(a_pass), 1);
    chk("sat_a_fc", int'(a_fc), 0);
    chk("sat_b_pc", int'(b_pc), 18);
    chk("sat_c_pc", int'(c_pc), 19);

    // Asynchronous reset mid-obligation: outputs drop at once, nothing reported later.
    cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 0, 1, 1);
    chk("pre_rst_a_pc", int'(a_pc), 2);
    chk("pre_rst_b_busy", int'(b_busy), 1);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    check_dut("rst_a", 0, 0, 0, 0, 0, 0, 0, 0);
    check_dut("rst_b", 1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #2;
    ASYNCRESETN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 1);
      check_dut($sformatf("post_rst%0d", k), 1, 0, 0, 0, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
